ex3_controller: RTL and testbench

- Handshake sequencing controller with 29 state flip-flops named S0..S28.
- S0..S5 are internal state; S6..S28 are driven directly as outputs.
- Tracks routing and beam handshake requests, the output request, an input-phase counter, a tap shift array and a timestamp counter.
- Sits between the program-mode source and the routing, beam and output handshake channels.

---
 rtl/ex3_pkg.sv | 17 +
 rtl/hs_flag.sv | 17 +
 rtl/ex3_controller.sv | 114 +++++++++++
 tb/tb_ex3_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex3_pkg.sv
// Shared bit positions and widths for the ex3 handshake sequencing controller.
package ex3_pkg;

  localparam int TAP_W = 8;
  localparam int TS_W  = 10;

  localparam int MODE_LSB  = 0;
  localparam int PHASE_LSB = 3;
  localparam int RT1       = 6;
  localparam int RT2       = 7;
  localparam int BM1       = 8;
  localparam int BM2       = 9;
  localparam int OUTQ      = 10;
  localparam int TAP_LSB   = 11;
  localparam int TS_LSB    = 19;

endpackage

// File: rtl/hs_flag.sv
// Single handshake request flag: clear beats set, otherwise hold; async active-high reset.
module hs_flag (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q
);

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (set) q <= 1'b1;
  end

endmodule

// File: rtl/ex3_controller.sv
// Handshake sequencing controller, state bits S0..S28 (S6..S28 exported).
// Build option: define TS_SATURATE_EN to make the timestamp stick at its maximum.
module ex3_controller
  import ex3_pkg::*;
(
  input  logic clock,
  input  logic Rdy1RtHS1,
  input  logic Rdy2RtHS1,
  input  logic Rdy1BmHS1,
  input  logic Rdy2BmHS1,
  input  logic InDoneHS1,
  input  logic RtTSHS1,
  input  logic TpArrayHS1,
  input  logic OutputHS1,
  input  logic WantBmHS1,
  input  logic WantRtHS1,
  input  logic OutAvHS1,
  input  logic FullOHS1,
  input  logic FullIHS1,
  input  logic Prog_2,
  input  logic Prog_1,
  input  logic Prog_0,
  output logic S26,
  output logic S25,
  output logic S22,
  output logic S27,
  output logic S14,
  output logic S11,
  output logic S17,
  output logic S10,
  output logic S13,
  output logic S16,
  output logic S6,
  output logic S12,
  output logic S19,
  output logic S18,
  output logic S15,
  output logic S7,
  output logic S9,
  output logic S20,
  output logic S28,
  output logic S23,
  output logic S8,
  output logic S21,
  output logic S24,
  input  logic reset
);

  logic S0, S1, S2, S3, S4, S5;

  logic [OUTQ:RT1]   flag_q;
  logic [28:0]       s_cur;
  logic [2:0]        phase_next;
  logic [TAP_W-1:0]  tap_next;
  logic [TS_W-1:0]   ts_cur;
  logic [TS_W-1:0]   ts_next;

  assign s_cur = {S28, S27, S26, S25, S24, S23, S22, S21, S20, S19,
                  S18, S17, S16, S15, S14, S13, S12, S11,
                  flag_q,
                  S5, S4, S3, S2, S1, S0};

  assign {S10, S9, S8, S7, S6} =
    {s_cur[OUTQ], s_cur[BM2], s_cur[BM1], s_cur[RT2], s_cur[RT1]};

  // Second-stage requests only arm once the first stage was already pending.
  hs_flag u_rt1 (.clock(clock), .reset(reset), .set(WantRtHS1),
                 .clr(Rdy1RtHS1), .q(flag_q[RT1]));
  hs_flag u_rt2 (.clock(clock), .reset(reset), .set(WantRtHS1 & s_cur[RT1]),
                 .clr(Rdy2RtHS1), .q(flag_q[RT2]));
  hs_flag u_bm1 (.clock(clock), .reset(reset), .set(WantBmHS1),
                 .clr(Rdy1BmHS1), .q(flag_q[BM1]));
  hs_flag u_bm2 (.clock(clock), .reset(reset), .set(WantBmHS1 & s_cur[BM1]),
                 .clr(Rdy2BmHS1), .q(flag_q[BM2]));
  hs_flag u_out (.clock(clock), .reset(reset), .set(OutAvHS1 & ~FullOHS1),
                 .clr(OutputHS1), .q(flag_q[OUTQ]));

  assign ts_cur = s_cur[TS_LSB +: TS_W];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_next = s_cur[PHASE_LSB +: 3];
    if (InDoneHS1 && !FullIHS1) phase_next = s_cur[PHASE_LSB +: 3] + 3'd1;

    tap_next = s_cur[TAP_LSB +: TAP_W];
    if (TpArrayHS1) tap_next = {s_cur[TAP_LSB +: TAP_W-1], RtTSHS1};

    ts_next = ts_cur;
    if (s_cur[MODE_LSB +: 3] == 3'b111) begin
      ts_next = '0;
    end else if (RtTSHS1 && !TpArrayHS1) begin
`ifdef TS_SATURATE_EN
      if (ts_cur != {TS_W{1'b1}}) ts_next = ts_cur + TS_W'(1);
`else
      ts_next = ts_cur + TS_W'(1);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {S2, S1, S0} <= 3'b000;
      {S5, S4, S3} <= 3'b000;
      {S18, S17, S16, S15, S14, S13, S12, S11} <= '0;
      {S28, S27, S26, S25, S24, S23, S22, S21, S20, S19} <= '0;
    end else begin
      {S2, S1, S0} <= {Prog_2, Prog_1, Prog_0};
      {S5, S4, S3} <= phase_next;
      {S18, S17, S16, S15, S14, S13, S12, S11} <= tap_next;
      {S28, S27, S26, S25, S24, S23, S22, S21, S20, S19} <= ts_next;
    end
  end

endmodule

// File: tb/tb_ex3_controller.sv
// Scoreboard bench for ex3_controller; honours TS_SATURATE_EN like the design.
module tb_ex3_controller;

  typedef struct packed {
    logic       rdy1rt;
    logic       rdy2rt;
    logic       rdy1bm;
    logic       rdy2bm;
    logic       indone;
    logic       rtts;
    logic       tparray;
    logic       outpuths;
    logic       wantbm;
    logic       wantrt;
    logic       outav;
    logic       fullo;
    logic       fulli;
    logic [2:0] prog;
  } in_t;

  logic clock;
  logic reset;
  in_t  stim;

  logic S6, S7, S8, S9, S10, S11, S12, S13, S14, S15, S16, S17;
  logic S18, S19, S20, S21, S22, S23, S24, S25, S26, S27, S28;

  logic [28:0] mstate;
  logic [28:0] sb[$];
  int n_checks;
  int n_fail;

  ex3_controller dut (
    .clock(clock),
    .Rdy1RtHS1(stim.rdy1rt), .Rdy2RtHS1(stim.rdy2rt),
    .Rdy1BmHS1(stim.rdy1bm), .Rdy2BmHS1(stim.rdy2bm),
    .InDoneHS1(stim.indone), .RtTSHS1(stim.rtts), .TpArrayHS1(stim.tparray),
    .OutputHS1(stim.outpuths), .WantBmHS1(stim.wantbm), .WantRtHS1(stim.wantrt),
    .OutAvHS1(stim.outav), .FullOHS1(stim.fullo), .FullIHS1(stim.fulli),
    .Prog_2(stim.prog[2]), .Prog_1(stim.prog[1]), .Prog_0(stim.prog[0]),
    .S26(S26), .S25(S25), .S22(S22), .S27(S27), .S14(S14), .S11(S11),
    .S17(S17), .S10(S10), .S13(S13), .S16(S16), .S6(S6), .S12(S12),
    .S19(S19), .S18(S18), .S15(S15), .S7(S7), .S9(S9), .S20(S20),
    .S28(S28), .S23(S23), .S8(S8), .S21(S21), .S24(S24),
    .reset(reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [28:0] observed();
    return {S28, S27, S26, S25, S24, S23, S22, S21, S20, S19,
            S18, S17, S16, S15, S14, S13, S12, S11,
            S10, S9, S8, S7, S6,
            dut.S5, dut.S4, dut.S3, dut.S2, dut.S1, dut.S0};
  endfunction

  function automatic logic [28:0] model(input logic [28:0] s, input in_t v);
    logic [28:0] n;
    n = s;
    n[2:0] = v.prog;
    if (v.indone && !v.fulli) n[5:3] = s[5:3] + 3'd1;
    n[6]  = v.rdy1rt   ? 1'b0 : (v.wantrt            ? 1'b1 : s[6]);
    n[7]  = v.rdy2rt   ? 1'b0 : ((v.wantrt && s[6])  ? 1'b1 : s[7]);
    n[8]  = v.rdy1bm   ? 1'b0 : (v.wantbm            ? 1'b1 : s[8]);
    n[9]  = v.rdy2bm   ? 1'b0 : ((v.wantbm && s[8])  ? 1'b1 : s[9]);
    n[10] = v.outpuths ? 1'b0 : ((v.outav && !v.fullo) ? 1'b1 : s[10]);
    if (v.tparray) n[18:11] = {s[17:11], v.rtts};
    if (s[2:0] == 3'b111) begin
      n[28:19] = 10'd0;
    end else if (v.rtts && !v.tparray) begin
`ifdef TS_SATURATE_EN
      if (s[28:19] != 10'd1023) n[28:19] = s[28:19] + 10'd1;
`else
      n[28:19] = s[28:19] + 10'd1;
`endif
    end
    return n;
  endfunction

  task automatic step(input in_t v);
    stim = v;
    mstate = model(mstate, v);
    sb.push_back(mstate);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    stim = '0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mstate = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    in_t v;
    logic [28:0] exp, got;
    for (int i = 0; i < 20; i++) begin
      v = in_t'(16'($urandom));
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_prerun[%0d]: got %h expected %h", i, got, exp);
      end
    end
    stim = in_t'(16'($urandom));
    #2 reset = 1'b1;
    #1 got = observed(); n_checks++;
    if (got !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", got, 29'd0);
    end
    @(posedge clock);
    stim = in_t'(16'($urandom)) | 16'h0200;
    @(negedge clock);
    got = observed(); n_checks++;
    if (got !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", got, 29'd0);
    end
    reset = 1'b0;
    mstate = '0;
    sb.delete();
  endtask

  task automatic test_mode();
    in_t v;
    logic [28:0] exp, got;
    do_reset();
    v = '0; v.prog = 3'b001;
    step(v);
    exp = sb.pop_front(); got = observed(); n_checks++;
    if (got !== exp || got[2:0] !== 3'b001) begin
      n_fail++;
      $display("FAIL mode_load: got %h expected %h", got, exp);
    end
    v = '0; v.rtts = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ts_count[%0d]: got %h expected %h", i, got, exp);
      end
    end
    v = '0; v.prog = 3'b111;
    step(v);
    exp = sb.pop_front(); got = observed(); n_checks++;
    if (got !== exp || got[28:19] !== 10'd5) begin
      n_fail++;
      $display("FAIL mode_clear_wait: got ts %0d expected ts 5", got[28:19]);
    end
    step(v);
    exp = sb.pop_front(); got = observed(); n_checks++;
    if (got !== exp || got[28:19] !== 10'd0) begin
      n_fail++;
      $display("FAIL mode_clear: got ts %0d expected ts 0", got[28:19]);
    end
  endtask

  task automatic test_rt_flags();
    in_t v;
    logic [28:0] exp, got;
    logic [1:0] want_flags [3];
    in_t seq [3];
    do_reset();
    seq[0] = '0; seq[0].wantrt = 1'b1;
    seq[1] = seq[0];
    seq[2] = seq[0]; seq[2].rdy1rt = 1'b1;
    want_flags[0] = 2'b01; want_flags[1] = 2'b11; want_flags[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step(seq[i]);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp || {S7, S6} !== want_flags[i]) begin
        n_fail++;
        $display("FAIL rt_flags[%0d]: got S7S6=%b expected %b", i, {S7, S6}, want_flags[i]);
      end
    end
  endtask

  task automatic test_bm_out();
    in_t seq [5];
    logic [28:0] exp, got;
    logic [2:0] want [5];
    do_reset();
    seq[0] = '0; seq[0].wantbm = 1'b1;
    seq[1] = seq[0];
    seq[2] = '0; seq[2].rdy2bm = 1'b1; seq[2].outav = 1'b1; seq[2].fullo = 1'b1;
    seq[3] = '0; seq[3].outav = 1'b1;
    seq[4] = '0; seq[4].outav = 1'b1; seq[4].outpuths = 1'b1; seq[4].rdy1bm = 1'b1;
    want[0] = 3'b001; want[1] = 3'b011; want[2] = 3'b001; want[3] = 3'b101; want[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step(seq[i]);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp || {S10, S9, S8} !== want[i]) begin
        n_fail++;
        $display("FAIL bm_out[%0d]: got S10S9S8=%b expected %b", i, {S10, S9, S8}, want[i]);
      end
    end
  endtask

  task automatic test_tap();
    in_t v;
    logic [28:0] exp, got;
    logic [7:0] bits;
    bits = 8'b01101100;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      v = '0; v.tparray = 1'b1; v.rtts = bits[i];
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL tap_shift[%0d]: got %h expected %h", 7 - i, got, exp);
      end
    end
    got = observed(); n_checks++;
    if (got[18:11] !== 8'b01101100 || got[28:19] !== 10'd0) begin
      n_fail++;
      $display("FAIL tap_final: got tap %b ts %0d expected tap 01101100 ts 0",
               got[18:11], got[28:19]);
    end
  endtask

  task automatic test_ts_wrap();
    in_t v;
    logic [28:0] exp, got;
    logic [9:0] want_1024, want_1025;
`ifdef TS_SATURATE_EN
    want_1024 = 10'd1023; want_1025 = 10'd1023;
`else
    want_1024 = 10'd0; want_1025 = 10'd1;
`endif
    do_reset();
    v = '0; v.rtts = 1'b1;
    for (int i = 1; i <= 1025; i++) begin
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ts_run[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 1023 && got[28:19] !== 10'd1023) begin
        n_checks++; n_fail++;
        $display("FAIL ts_max: got %0d expected 1023", got[28:19]);
      end
      if (i == 1024) begin
        n_checks++;
        if (got[28:19] !== want_1024) begin
          n_fail++;
          $display("FAIL ts_edge: got %0d expected %0d", got[28:19], want_1024);
        end
      end
    end
    got = observed(); n_checks++;
    if (got[28:19] !== want_1025) begin
      n_fail++;
      $display("FAIL ts_wrap: got %0d expected %0d", got[28:19], want_1025);
    end
  endtask

  task automatic test_load_state();
    in_t v;
    logic [28:0] exp, got;
    logic [7:0] bits;
    bits = 8'b01101100;
    do_reset();
    v = '0; v.prog = 3'b001; v.wantrt = 1'b1;
    step(v); void'(sb.pop_front());
    step(v); void'(sb.pop_front());
    for (int i = 7; i >= 0; i--) begin
      v = '0; v.prog = 3'b001; v.tparray = 1'b1; v.rtts = bits[i];
      step(v); void'(sb.pop_front());
    end
    v = '0; v.prog = 3'b001; v.rtts = 1'b1;
    step(v);
    exp = sb.pop_front(); got = observed(); n_checks++;
    if (got !== 29'b00000000010110110000011000001 || got !== exp) begin
      n_fail++;
      $display("FAIL load_state: got %b expected %b", got, 29'b00000000010110110000011000001);
    end
    v = '0; v.prog = 3'b001; v.indone = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp || got[5:3] !== 3'(i % 8)) begin
        n_fail++;
        $display("FAIL phase[%0d]: got %0d expected %0d", i, got[5:3], i % 8);
      end
    end
    v.fulli = 1'b1;
    step(v);
    exp = sb.pop_front(); got = observed(); n_checks++;
    if (got !== exp || got[5:3] !== 3'd0) begin
      n_fail++;
      $display("FAIL phase_full: got %0d expected 0", got[5:3]);
    end
  endtask

  task automatic test_back_to_back();
    in_t v;
    logic [28:0] exp, got;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v = in_t'(16'($urandom));
      if (v.prog == 3'b111 && (i % 4) != 0) v.prog = 3'b011;
      step(v);
      exp = sb.pop_front(); got = observed(); n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stim     = '0;
    reset    = 1'b1;
    mstate   = '0;
    #12;
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_mode();
    test_rt_flags();
    test_bm_out();
    test_tap();
    test_ts_wrap();
    test_load_state();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
